// File: rtl/mac32_dot_seq.sv
// mac32_dot_seq: sequencer for a floating-point dot product on an external
// combinational single-precision MAC (T = A + B*C). It holds the running sum
// in a register that feeds the MAC A input. It ORs the MAC exception flags
// over the whole vector. It returns one rounded result plus the accrued
// fflags per command through a valid/ready output.
module mac32_dot_seq #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_RM    = 3,
  parameter int PARM_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  init_i,
  input  logic [PARM_RM-1:0]    rm_i,
  output logic                  busy_o,
  // operand stream
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PARM_XLEN-1:0]  b_i,
  input  logic [PARM_XLEN-1:0]  c_i,
  // MAC drive / return
  output logic [PARM_XLEN-1:0]  mac_a_o,
  output logic [PARM_XLEN-1:0]  mac_b_o,
  output logic [PARM_XLEN-1:0]  mac_c_o,
  output logic [PARM_RM-1:0]    mac_rm_o,
  input  logic [PARM_XLEN-1:0]  mac_result_i,
  input  logic                  mac_nv_i,
  input  logic                  mac_of_i,
  input  logic                  mac_uf_i,
  input  logic                  mac_nx_i,
  // result
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PARM_XLEN-1:0]  out_result_o,
  output logic [4:0]            out_fflags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PARM_XLEN-1:0]    acc_q;
  logic [PARM_XLEN-1:0]    b_q;
  logic [PARM_XLEN-1:0]    c_q;
  logic                    op_vld_q;   // b_q/c_q hold a pair not yet folded into acc_q
  logic [PARM_LEN_W-1:0]   cnt_q;      // pairs still to accept
  logic [PARM_RM-1:0]      rm_q;
  logic [3:0]              flags_q;    // {NV, OF, UF, NX}
  logic                    accept;

  // The MAC sees only registered operands. The path register -> MAC -> register
  // is the one single-cycle path, and no MAC result reaches an output
  // combinationally.
  assign mac_a_o  = acc_q;
  assign mac_b_o  = b_q;
  assign mac_c_o  = c_q;
  assign mac_rm_o = rm_q;

  // Status and result outputs are decoded from registered state only.
  assign busy_o       = (state_q != IDLE);
  assign in_ready_o   = (state_q == RUN) && (cnt_q != '0);
  assign accept       = in_valid_i && in_ready_o;
  assign out_valid_o  = (state_q == DONE);
  assign out_result_o = acc_q;
  assign out_fflags_o = {flags_q[3], 1'b0, flags_q[2:0]};

  // Command FSM with the operand pipeline and accumulator. Accept and commit
  // may share an edge, which gives a throughput of one pair per cycle.
  // NOTE: every register here uses non-blocking assignment. The commit
  // therefore reads the old b_q/c_q, even when a new pair is accepted on the
  // same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_vld_q <= 1'b0;
      cnt_q    <= '0;
      rm_q     <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q    <= init_i;
            cnt_q    <= len_i;
            rm_q     <= rm_i;
            flags_q  <= '0;
            op_vld_q <= 1'b0;
            state_q  <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            b_q      <= b_i;
            c_q      <= c_i;
            cnt_q    <= cnt_q - PARM_LEN_W'(1);
            op_vld_q <= 1'b1;
          end else begin
            op_vld_q <= 1'b0;
          end
          if (op_vld_q) begin
            acc_q   <= mac_result_i;
            flags_q <= flags_q | {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i};
          end
          // The final commit lands on the same edge that enters DONE.
          if (op_vld_q && (cnt_q == '0)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac32_dot_seq.sv
// Self-checking bench for mac32_dot_seq. The external MAC is modelled as a
// lookup of hand-computed single-precision results for the operand triples
// the vectors produce.
module tb_mac32_dot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] init = '0;
  logic [2:0]  rm = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] b = '0;
  logic [31:0] c = '0;
  logic [31:0] mac_a, mac_b, mac_c;
  logic [2:0]  mac_rm;
  logic [31:0] mac_result;
  logic        mac_nv, mac_of, mac_uf, mac_nx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac32_dot_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .len_i        (len),
    .init_i       (init),
    .rm_i         (rm),
    .busy_o       (busy),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .b_i          (b),
    .c_i          (c),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_c_o      (mac_c),
    .mac_rm_o     (mac_rm),
    .mac_result_i (mac_result),
    .mac_nv_i     (mac_nv),
    .mac_of_i     (mac_of),
    .mac_uf_i     (mac_uf),
    .mac_nx_i     (mac_nx),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_fflags_o (out_fflags)
  );

  // MAC stand-in: returns {result, nv, of, uf, nx} for A + B*C.
  function automatic logic [35:0] mac_model(input logic [31:0] a, input logic [31:0] bb,
                                            input logic [31:0] cc);
    case ({a, bb, cc})
      {32'h00000000, 32'h3F800000, 32'h40000000}: return {32'h40000000, 4'b0000}; // 0+1*2
      {32'h40000000, 32'h40000000, 32'h40400000}: return {32'h41000000, 4'b0000}; // 2+2*3
      {32'h41000000, 32'h40400000, 32'h3F800000}: return {32'h41300000, 4'b0000}; // 8+3*1
      {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h40000000}: return {32'h7F800000, 4'b0101}; // max+2max
      {32'h7F800000, 32'h3F800000, 32'h3F800000}: return {32'h7F800000, 4'b0000}; // inf+1
      {32'h3F800000, 32'h00000000, 32'h7F800000}: return {32'h7FC00000, 4'b1000}; // 1+0*inf
      {32'h00000000, 32'h00800001, 32'h3F000000}: return {32'h00400000, 4'b0011}; // tiny, inexact
      default:                                    return {32'hDEADBEEF, 4'b0000};
    endcase
  endfunction

  always_comb begin
    {mac_result, mac_nv, mac_of, mac_uf, mac_nx} = mac_model(mac_a, mac_b, mac_c);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string           name;
    logic [7:0]      len;
    logic [31:0]     init;
    logic [2:0]      rm;
    logic [2:0][31:0] b;
    logic [2:0][31:0] c;
    logic [31:0]     exp_result;
    logic [4:0]      exp_fflags;
  } vec_t;

  vec_t vecs[5];

  // Issue one command, stream its pairs back to back, and check result,
  // flags and latency. out_ready is high, so DONE lasts one cycle.
  task automatic run_vec(input vec_t v);
    int edges;
    start = 1'b1; len = v.len; init = v.init; rm = v.rm;
    step();
    start = 1'b0;
    check({v.name, " busy"}, 32'(busy), 32'd1);
    check({v.name, " in_ready after start"}, 32'(in_ready), (v.len != 0) ? 32'd1 : 32'd0);
    check({v.name, " mac_rm"}, 32'(mac_rm), 32'(v.rm));
    for (int i = 0; i < int'(v.len); i++) begin
      b = v.b[i]; c = v.c[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, " latency"}, 32'(edges), (v.len != 0) ? 32'd1 : 32'd0);
    check({v.name, " result"}, out_result, v.exp_result);
    check({v.name, " fflags"}, 32'(out_fflags), 32'(v.exp_fflags));
    check({v.name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    step();
    check({v.name, " back to idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"basic", 8'd3, 32'h00000000, 3'd0,
                {32'h40400000, 32'h40000000, 32'h3F800000},
                {32'h3F800000, 32'h40400000, 32'h40000000},
                32'h41300000, 5'b00000};
    vecs[1] = '{"zero_len", 8'd0, 32'h40490FDB, 3'd0, '0, '0, 32'h40490FDB, 5'b00000};
    vecs[2] = '{"overflow", 8'd2, 32'h7F7FFFFF, 3'd0,
                {32'h0, 32'h3F800000, 32'h7F7FFFFF},
                {32'h0, 32'h3F800000, 32'h40000000},
                32'h7F800000, 5'b00101};
    vecs[3] = '{"invalid", 8'd1, 32'h3F800000, 3'd4,
                {32'h0, 32'h0, 32'h00000000},
                {32'h0, 32'h0, 32'h7F800000},
                32'h7FC00000, 5'b10000};
    vecs[4] = '{"underflow", 8'd1, 32'h00000000, 3'd0,
                {32'h0, 32'h0, 32'h00800001},
                {32'h0, 32'h0, 32'h3F000000},
                32'h00400000, 5'b00011};

    // Reset state: everything reads zero.
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst out_fflags", 32'(out_fflags), 32'd0);
    check("rst mac_a", mac_a, 32'd0);
    check("rst mac_rm", 32'(mac_rm), 32'd0);
    rst = 1'b1;
    step();

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Handshake: gapped input, spurious starts, output backpressure.
    begin : handshake
      logic [31:0] held_result;
      logic [4:0]  held_flags;
      int          edges;
      out_ready = 1'b0;
      start = 1'b1; len = 8'd3; init = 32'h0; rm = 3'd0;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        b = vecs[0].b[i]; c = vecs[0].c[i]; in_valid = 1'b1;
        if (i == 1) begin
          start = 1'b1; len = 8'd5; init = 32'h12345678;
        end
        step();
        start = 1'b0;
        // Gap cycle. After the last pair, drive a junk pair that must be ignored.
        b = 32'h12345678; c = 32'h12345678;
        in_valid = (i == 2);
        if (i == 2) check("hs in_ready at cnt 0", 32'(in_ready), 32'd0);
        step();
      end
      in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 20) begin
        step();
        edges++;
      end
      check("hs out_valid", 32'(out_valid), 32'd1);
      check("hs result", out_result, 32'h41300000);
      check("hs fflags", 32'(out_fflags), 32'd0);
      held_result = out_result;
      held_flags  = out_fflags;
      for (int i = 0; i < 5; i++) begin
        if (i == 2) begin
          start = 1'b1; len = 8'd0; init = 32'hCAFEF00D;
        end
        step();
        start = 1'b0;
        check("hs stall valid", 32'(out_valid), 32'd1);
        check("hs stall result", out_result, held_result);
        check("hs stall fflags", 32'(out_fflags), 32'(held_flags));
      end
      out_ready = 1'b1;
      step();
      check("hs valid cleared", 32'(out_valid), 32'd0);
      check("hs idle", 32'(busy), 32'd0);
      step();
      check("hs no queued start", 32'(busy), 32'd0);
    end

    // Asynchronous reset mid-run after one committed pair, then a clean rerun.
    start = 1'b1; len = 8'd3; init = 32'h7F7FFFFF; rm = 3'd2;
    step();
    start = 1'b0;
    b = 32'h7F7FFFFF; c = 32'h40000000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("pre-reset acc", mac_a, 32'h7F800000);
    #3 rst = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd0);
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst out_result", out_result, 32'd0);
    check("arst out_fflags", 32'(out_fflags), 32'd0);
    check("arst mac_b", mac_b, 32'd0);
    check("arst mac_rm", 32'(mac_rm), 32'd0);
    step();
    #2 rst = 1'b1;
    step();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
